// File: rtl/alu_share_seq_pkg.sv
// Shared ALU control codes and the sequencer state type used by the
// ALU time-sharing sequencer and the ALU it drives.
package alu_share_seq_pkg;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRA = 3'd6;
  localparam logic [2:0] ALU_MUL = 3'd7;

  typedef enum logic [1:0] {
    ALUSEQ_IDLE,
    ALUSEQ_EXEC,
    ALUSEQ_RESP
  } aluseq_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by both requesters; Zero_o flags a zero result.
module alu
  import alu_share_seq_pkg::*;
(
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic [2:0]  ALUCtrl_i,
  output logic [31:0] data_o,
  output logic        Zero_o
);

  always_comb begin
    data_o = '0;
    case (ALUCtrl_i)
      ALU_AND: data_o = data1_i & data2_i;
      ALU_OR:  data_o = data1_i | data2_i;
      ALU_ADD: data_o = data1_i + data2_i;
      ALU_SUB: data_o = data1_i - data2_i;
      ALU_XOR: data_o = data1_i ^ data2_i;
      ALU_SLL: data_o = data1_i << data2_i[4:0];
      ALU_SRA: data_o = $signed(data1_i) >>> data2_i[4:0];
      ALU_MUL: data_o = data1_i * data2_i;
    endcase
  end

  assign Zero_o = (data_o == '0);

endmodule

// File: rtl/alu_share_seq_rr_arb2.sv
// Two-way round-robin arbiter: a lone valid wins outright; on contention
// the requester named by ptr wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_share_seq.sv
// Time-shares one ALU between two requesters: round-robin grant, latched
// operands held on the ALU for 1 (or MUL_CYCLES) cycles, valid/ready response.
module alu_share_seq
  import alu_share_seq_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic        req1_valid_i,
  output logic        req0_ready_o,
  output logic        req1_ready_o,
  input  logic [2:0]  req0_op_i,
  input  logic [2:0]  req1_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_data_i,
  output logic        busy_o
);

  localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  aluseq_state_t state, state_next;

  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q, res_q;
  logic             id_q, ptr_q, idle;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       grant;
  logic [2:0]       sel_op;
  logic [31:0]      sel_a, sel_b;

  rr_arb2 u_arb (
    .valid ({req1_valid_i, req0_valid_i}),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign idle   = (state == ALUSEQ_IDLE);
  assign sel_op = grant[1] ? req1_op_i : req0_op_i;
  assign sel_a  = grant[1] ? req1_a_i  : req0_a_i;
  assign sel_b  = grant[1] ? req1_b_i  : req0_b_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ALUSEQ_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ALUSEQ_IDLE: if (|grant)          state_next = ALUSEQ_EXEC;
      ALUSEQ_EXEC: if (cnt_q == '0)     state_next = ALUSEQ_RESP;
      ALUSEQ_RESP: if (rsp_ready_i)     state_next = ALUSEQ_IDLE;
      default:                          state_next = ALUSEQ_IDLE;
    endcase
  end

  // Operand registers keep the last op after completion so the ALU inputs
  // only ever change at a grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
      ptr_q <= 1'b0;
    end else begin
      if (idle && (|grant)) begin
        op_q  <= sel_op;
        a_q   <= sel_a;
        b_q   <= sel_b;
        id_q  <= grant[1];
        cnt_q <= (sel_op == ALU_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
      end
      if (state == ALUSEQ_EXEC) begin
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        else             res_q <= alu_data_i;
      end
      if (state == ALUSEQ_RESP && rsp_ready_i) ptr_q <= ~id_q;
    end
  end

  assign req0_ready_o = idle & grant[0];
  assign req1_ready_o = idle & grant[1];
  assign rsp_valid_o  = (state == ALUSEQ_RESP);
  assign rsp_id_o     = id_q;
  assign rsp_data_o   = res_q;
  assign alu_data1_o  = a_q;
  assign alu_data2_o  = b_q;
  assign alu_ctrl_o   = op_q;
  assign busy_o       = ~idle;

endmodule

// File: tb/tb_alu_share_seq.sv
// Bench for alu_share_seq: directed literal scenarios plus randomized traffic,
// all checked every cycle against a transaction-level timing/result model.
module tb_alu_share_seq;
  import alu_share_seq_pkg::*;

  localparam int unsigned MUL_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_id, busy, alu_zero;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data, alu_d1, alu_d2, alu_data;
  logic [2:0]  alu_ctrl;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  alu_share_seq #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid),
    .req1_valid_i (req1_valid),
    .req0_ready_o (req0_ready),
    .req1_ready_o (req1_ready),
    .req0_op_i    (req0_op),
    .req1_op_i    (req1_op),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_data_o   (rsp_data),
    .alu_data1_o  (alu_d1),
    .alu_data2_o  (alu_d2),
    .alu_ctrl_o   (alu_ctrl),
    .alu_data_i   (alu_data),
    .busy_o       (busy)
  );

  alu u_alu (
    .data1_i   (alu_d1),
    .data2_i   (alu_d2),
    .ALUCtrl_i (alu_ctrl),
    .data_o    (alu_data),
    .Zero_o    (alu_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] ones;
    logic [63:0] prod;
    int unsigned sh;
    ones = '1;
    sh   = int'(b % 32);
    prod = 64'(a) * 64'(b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << sh;
      ALU_SRA: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
      default: return prod[31:0];
    endcase
  endfunction

  function automatic int unsigned lat_of(input logic [2:0] op);
    return (op == ALU_MUL) ? MUL_CYCLES : 1;
  endfunction

  // Transaction-level model: one op in flight, response due lat+1 cycles after its handshake.
  int unsigned cyc = 0, m_resp_cyc = 0;
  bit          m_busy = 0, m_pref = 0, m_id = 0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  bit          e_r0, e_r1, e_vld;

  always @(negedge clk) begin
    if (!rst_i) begin
      m_busy = 0; m_pref = 0; m_id = 0; m_op = '0; m_a = '0; m_b = '0;
      chk("rst ready0", 32'(req0_ready), 0);
      chk("rst ready1", 32'(req1_ready), 0);
      chk("rst rsp_valid", 32'(rsp_valid), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst rsp_id", 32'(rsp_id), 0);
      chk("rst rsp_data", rsp_data, 0);
      chk("rst alu_d1", alu_d1, 0);
      chk("rst alu_d2", alu_d2, 0);
      chk("rst alu_ctrl", 32'(alu_ctrl), 0);
    end else begin
      e_r0  = !m_busy && req0_valid && (!req1_valid || !m_pref);
      e_r1  = !m_busy && req1_valid && (!req0_valid || m_pref);
      e_vld = m_busy && (cyc >= m_resp_cyc);
      chk("m ready0", 32'(req0_ready), 32'(e_r0));
      chk("m ready1", 32'(req1_ready), 32'(e_r1));
      chk("m rsp_valid", 32'(rsp_valid), 32'(e_vld));
      chk("m busy", 32'(busy), 32'(m_busy));
      chk("m alu_d1", alu_d1, m_a);
      chk("m alu_d2", alu_d2, m_b);
      chk("m alu_ctrl", 32'(alu_ctrl), 32'(m_op));
      chk("m alu_zero", 32'(alu_zero), 32'(alu_ref(m_op, m_a, m_b) == 32'd0));
      if (e_vld) begin
        chk("m rsp_data", rsp_data, m_res);
        chk("m rsp_id", 32'(rsp_id), 32'(m_id));
      end
      if (e_vld && rsp_ready) begin
        m_busy = 0;
        m_pref = !m_id;
      end else if (e_r0 || e_r1) begin
        m_busy = 1;
        m_id   = e_r1;
        m_op   = e_r1 ? req1_op : req0_op;
        m_a    = e_r1 ? req1_a  : req0_a;
        m_b    = e_r1 ? req1_b  : req0_b;
        m_res  = alu_ref(m_op, m_a, m_b);
        m_resp_cyc = cyc + lat_of(m_op) + 1;
      end
    end
    cyc++;
  end

  task automatic drive(input int unsigned port, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic wait_rsp(input string name, input int unsigned lat, input logic [31:0] data,
                          input logic id);
    int unsigned n = 0;
    logic got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = rsp_valid;
    end
    chk({name, " valid"}, 32'(got), 1);
    chk({name, " latency"}, n, lat + 1);
    chk({name, " data"}, rsp_data, data);
    chk({name, " id"}, 32'(rsp_id), 32'(id));
  endtask

  task automatic single(input string name, input int unsigned port, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(posedge clk); #1;
    drive(port, 1'b1, op, a, b);
    @(negedge clk);
    chk({name, " ready"}, 32'(port == 0 ? req0_ready : req1_ready), 1);
    @(posedge clk); #1;
    drive(port, 1'b0, op, a, b);
    wait_rsp(name, lat_of(op), exp, port[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic s0, s1;
    #2 rst_i = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_i = 1'b1;

    single("add", 0, ALU_ADD, 32'd5, 32'd7, 32'd12);

    @(posedge clk); #1;
    drive(1, 1'b1, ALU_MUL, 32'd6, 32'd7);
    @(negedge clk);
    chk("mul ready1", 32'(req1_ready), 1);
    @(posedge clk); #1;
    drive(1, 1'b0, ALU_MUL, 32'd6, 32'd7);
    repeat (MUL_CYCLES) begin
      @(negedge clk);
      chk("mul exec d1", alu_d1, 32'd6);
      chk("mul exec d2", alu_d2, 32'd7);
      chk("mul exec ctrl", 32'(alu_ctrl), 32'(ALU_MUL));
      chk("mul exec no rsp", 32'(rsp_valid), 0);
    end
    @(negedge clk);
    chk("mul rsp valid", 32'(rsp_valid), 1);
    chk("mul rsp data", rsp_data, 32'd42);
    chk("mul rsp id", 32'(rsp_id), 1);

    for (int unsigned r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      drive(0, 1'b1, ALU_SUB, 32'd10, 32'd3);
      drive(1, 1'b1, ALU_XOR, 32'hF0, 32'hFF);
      @(negedge clk);
      chk("both ready0", 32'(req0_ready), 1);
      chk("both ready1", 32'(req1_ready), 0);
      @(posedge clk); #1;
      drive(0, 1'b0, ALU_SUB, 32'd10, 32'd3);
      wait_rsp("both sub", 1, 32'd7, 1'b0);
      @(negedge clk);
      chk("both ready1 next", 32'(req1_ready), 1);
      @(posedge clk); #1;
      drive(1, 1'b0, ALU_XOR, 32'hF0, 32'hFF);
      wait_rsp("both xor", 1, 32'h0F, 1'b1);
    end

    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive(0, 1'b1, ALU_ADD, 32'd100, 32'd23);
    @(negedge clk);
    chk("bp ready0", 32'(req0_ready), 1);
    @(posedge clk); #1;
    drive(0, 1'b1, ALU_OR, 32'h0F00, 32'h00F0);
    wait_rsp("bp", 1, 32'd123, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("bp hold valid", 32'(rsp_valid), 1);
      chk("bp hold data", rsp_data, 32'd123);
      chk("bp hold id", 32'(rsp_id), 0);
      chk("bp hold ready0", 32'(req0_ready), 0);
      chk("bp hold ready1", 32'(req1_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release valid", 32'(rsp_valid), 1);
    @(negedge clk);
    chk("bp next grant", 32'(req0_ready), 1);
    @(posedge clk); #1;
    drive(0, 1'b0, ALU_OR, 32'h0F00, 32'h00F0);
    wait_rsp("bp next", 1, 32'h0FF0, 1'b0);

    single("sra", 1, ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    single("sll", 0, ALU_SLL, 32'd1, 32'd31, 32'h8000_0000);

    @(posedge clk); #1;
    drive(1, 1'b1, ALU_MUL, 32'd9, 32'd9);
    @(negedge clk);
    chk("rstmul ready1", 32'(req1_ready), 1);
    @(posedge clk); #1;
    drive(1, 1'b0, ALU_MUL, 32'd9, 32'd9);
    @(posedge clk); #3 rst_i = 1'b0;
    #1;
    chk("async busy", 32'(busy), 0);
    chk("async rsp_valid", 32'(rsp_valid), 0);
    chk("async rsp_data", rsp_data, 0);
    chk("async alu_d1", alu_d1, 0);
    chk("async alu_d2", alu_d2, 0);
    chk("async alu_ctrl", 32'(alu_ctrl), 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post rst no rsp", 32'(rsp_valid), 0);
    end
    single("add after rst", 0, ALU_ADD, 32'd1, 32'd1, 32'd2);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      s0 = req0_valid && req0_ready;
      s1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (!req0_valid || s0)
        drive(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)));
      if (!req1_valid || s1)
        drive(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)));
      rsp_ready = ($urandom_range(0, 9) < 7);
    end

    @(negedge clk);
    s0 = req0_valid && req0_ready;
    s1 = req1_valid && req1_ready;
    @(posedge clk); #1;
    if (s0) req0_valid = 1'b0;
    if (s1) req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (40) begin
      @(negedge clk);
      s0 = req0_valid && req0_ready;
      s1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (s0) req0_valid = 1'b0;
      if (s1) req1_valid = 1'b0;
    end
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_seq.md
# alu_share_seq

Sequencer that time-shares the single ALU between two requesters (e.g. main datapath and a secondary execution unit). Arbitrates round-robin, latches the winner's operation and operands, drives the ALU for one cycle (or `MUL_CYCLES` cycles for multiply, so MUL can be a multicycle path), captures the result and returns it on a valid/ready response port. Sits between the requesters and the ALU; the ALU itself is unchanged.

## Interface
- `MUL_CYCLES`, 3, ALU cycles granted to `ALU_MUL` (legal ≥1); all other ops get 1
- `clk_i` in 1: clock; everything on rising edge
- `rst_i` in 1: asynchronous, active-low reset
- `req0_valid_i` / `req1_valid_i` in 1: request pending
- `req0_ready_o` / `req1_ready_o` out 1: request accepted this cycle
- `req0_op_i` / `req1_op_i` in 3: ALU control code (`ALU_*` defines)
- `req0_a_i`, `req0_b_i` / `req1_a_i`, `req1_b_i` in 32: operands
- `rsp_valid_o` out 1: result valid
- `rsp_ready_i` in 1: consumer takes result
- `rsp_id_o` out 1: requester that issued the result (0/1)
- `rsp_data_o` out 32: result
- `alu_data1_o`, `alu_data2_o` out 32: to ALU `data1_i`/`data2_i`
- `alu_ctrl_o` out 3: to ALU `ALUCtrl_i`
- `alu_data_i` in 32: from ALU `data_o`; ALU `Zero_o` unused
- `busy_o` out 1: state ≠ IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any `reqN_valid_i`, grant one: single valid → that one; both → requester not served last (pointer resets to favour req0). `reqN_ready_o`=1 only for grantee, only in IDLE (combinational from valid + pointer). On handshake latch op/a/b/id, load counter = `MUL_CYCLES`-1 for `ALU_MUL` else 0, go EXEC.
- EXEC: ALU outputs driven from latched registers, stable for the whole state. Counter ≠0 → decrement. Counter =0 → capture `alu_data_i` into result register, go RESP.
- RESP: `rsp_valid_o`=1; data/id stable. `rsp_ready_i`=1 → pointer := other requester, go IDLE. No grants in EXEC/RESP.
- ALU outputs always reflect operand/op registers (no toggling outside EXEC).
- Unused op codes: processed as 1-cycle ops; returned data is whatever ALU drives (unchecked).
- Requester must hold op/a/b stable while valid and not ready; not checked.

## Timing
- Reset values: all ready/valid 0, `rsp_id_o` 0, `rsp_data_o` 0, ALU operand/ctrl outputs 0, `busy_o` 0, state IDLE, pointer favours req0, counter 0.
- Handshake cycle T → EXEC T+1..T+L (L=1, or `MUL_CYCLES` for MUL) → `rsp_valid_o` from T+L+1.
- Earliest next grant: cycle after response accepted. Max throughput: one op per L+2 cycles with `rsp_ready_i` held 1.
- Backpressure: RESP holds indefinitely; requests wait, ready stays 0.
- Reset mid-operation: immediate return to reset values; in-flight op dropped, no response.
- Pointer updates only on response acceptance, not at grant.

## Structure
- Add state encodings `ALUSEQ_IDLE/EXEC/RESP` to the shared header next to the `ALU_*` codes; reuse `ALU_MUL` for latency selection.
- One sub-module: `rr_arb2` (2-way round-robin arbiter: valids + pointer in, one-hot grant out, combinational).
- Bench instantiates the real ALU wired to the `alu_*` ports.

## Test plan
- Reset, req0 ADD a=5 b=7 → `req0_ready_o` at T, `rsp_valid_o` at T+2, data 12, id 0.
- req1 MUL a=6 b=7, `MUL_CYCLES`=3 → response at T+4, data 42, id 1; ALU inputs constant T+1..T+3.
- Both valid after reset: req0 SUB 10,3 and req1 XOR 0xF0,0xFF → req0 first (7), then req1 (0x0F); repeat both → req0 first again (pointer alternates).
- Backpressure: hold `rsp_ready_i`=0 for 5 cycles with req0 valid → `rsp_valid_o`/data/id stable, both readies 0; on release, next grant the following cycle.
- SRA a=0x80000000 b=4 → 0xF8000000; SLL a=1 b=31 → 0x80000000.
- Assert `rst_i`=0 during MUL EXEC → outputs to reset values asynchronously, no response; after release ADD 1+1 → 2 normally.
